motor_step_scheduler: RTL and testbench
=======================================

Name: motor_step_scheduler

Overview:
Sequences the two tracker motor axes (theta, phi) from the 2-bit pos/neg move requests produced by the movement controller. Converts each request into a timed step/dir/enable drive and grants only one axis at a time, using round-robin. Inserts a dead time on every grant and on every direction reversal, and caps the steps per grant so that neither axis starves the other. Sits between the movement controller and the motor driver pins.

Parameters:
STEP_DIV, 50000, clock cycles per full step period (high + low); must be > PULSE_W.
PULSE_W, 100, step-high width in cycles; must be ≥ 1.
DEAD_T, 1000, cycles with en/dir stable before the first step of a grant or after a reversal; must be ≥ 1.
MAX_STEPS, 1024, step quota per grant while the other axis is requesting.
CNT_W, 16, width of the timing and step counters; must hold max(STEP_DIV, DEAD_T, MAX_STEPS).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
enable  input  1  global drive enable
theta_pos  input  2  2'b01 = move theta positive; any other code = idle
theta_neg  input  2  2'b01 = move theta negative; any other code = idle
phi_pos  input  2  2'b01 = move phi positive; any other code = idle
phi_neg  input  2  2'b01 = move phi negative; any other code = idle
theta_step  output  1  theta step pulse
theta_dir  output  1  1 = positive
theta_en  output  1  theta driver enable
phi_step  output  1  phi step pulse
phi_dir  output  1  1 = positive
phi_en  output  1  phi driver enable
busy  output  1  high in every state except IDLE
axis  output  1  granted axis: 0 = theta, 1 = phi; holds last value in IDLE
fault  output  1  sticky; set when pos and neg are both 01 on one axis

Behaviour:
- All outputs are registered. Reset drives every output to 0, forces the state to IDLE, clears all counters, and sets the round-robin priority to theta. Reset is immediate, including mid-pulse.
- Request decode per axis:
  - pos==01, neg!=01 → request positive.
  - neg==01, pos!=01 → request negative.
  - Both 01 → no request for that axis, and fault is set.
- States: IDLE, SETUP, STEP_HI, STEP_LO, RELEASE.
- IDLE:
  - Outputs are low.
  - If enable and at least one axis requests: grant the requesting axis. If both request, grant the priority axis.
  - Latch its direction, set axis, go to SETUP.
  - Timing: en/dir are high/valid from the cycle after the request is sampled.
- SETUP:
  - Hold en=1 and dir for DEAD_T cycles, step=0.
  - Then go to STEP_HI with the step count cleared.
- STEP_HI: step=1 for exactly PULSE_W cycles, then STEP_LO. A high pulse is never truncated, except by rst.
- STEP_LO:
  - step=0 for STEP_DIV-PULSE_W cycles.
  - On the final cycle, increment the step count (saturating at MAX_STEPS) and resample the requests.
- Decision at the end of STEP_LO, in this order:
  1. enable=0, or the granted axis no longer requests → RELEASE.
  2. Granted axis requests the opposite direction → update dir, go to SETUP. The step count is kept.
  3. Step count == MAX_STEPS and the other axis is requesting → RELEASE.
  4. Otherwise → STEP_HI. The quota is ignored while the other axis is idle.
- enable falling during SETUP: go to RELEASE immediately, with no step issued.
- RELEASE:
  - Lasts one cycle: en=0, step=0, dir held.
  - Priority passes to the other axis.
  - Then IDLE.
- The non-granted axis always has step=en=0. The two en outputs are never high together.
- Requests are sampled only in IDLE, in SETUP (enable only), and on the last STEP_LO cycle. Changes between those points are ignored.
- fault is cleared only by rst.

Decomposition:
- Shared package (motor_pkg):
  - State enum: IDLE, SETUP, STEP_HI, STEP_LO, RELEASE.
  - Request-code constants: MOVE = 2'b01, STOP = 2'b00.
  - Axis constants: THETA = 0, PHI = 1.
- Natural sub-module: step_timer. It is a loadable down-counter with a done flag, reused for the SETUP, STEP_HI and STEP_LO intervals.

Test Plan (STEP_DIV=10, PULSE_W=3, DEAD_T=4, MAX_STEPS=3):
- Theta-positive single request: theta_pos=01 held → theta_en and theta_dir=1 one cycle later; first theta_step rise 4 cycles after that. Pulses are 3 cycles high with a 10-cycle period. phi_en stays 0.
- Drop mid-pulse: theta_pos→00 during STEP_HI → the 3-cycle pulse completes, then 7 low cycles, then theta_en=0 for one RELEASE cycle, then IDLE with busy=0.
- Reversal: theta_pos→00 and theta_neg→01 mid-run → at the STEP_LO end, theta_dir=0 with 4 dead cycles before the next step rise. theta_en stays 1 throughout.
- Arbitration: both axes requesting from reset → theta is granted and gives 3 steps, then RELEASE. phi is granted next and gives 3 steps, then back to theta. The two en signals never overlap.
- Conflict: phi_pos=01 and phi_neg=01 → phi is never granted and fault=1, which stays 1 after the requests clear until rst.
- Reset mid-operation: rst asserted during theta STEP_HI → all outputs 0 in the same cycle. After release, an idle request set stays IDLE, and the next grant goes to theta.

Source files
------------

// File: rtl/motor_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : motor_pkg
// Description : Shared types and constants for the two-axis step scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

  // Scheduler states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STEP_HI = 3'd2,
    STEP_LO = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Movement-controller request codes.
  localparam logic [1:0] MOVE = 2'b01;
  localparam logic [1:0] STOP = 2'b00;

  // Axis identifiers.
  localparam logic THETA = 1'b0;
  localparam logic PHI   = 1'b1;

  // True when a request code asks for motion.
  function automatic logic is_move(input logic [1:0] code);
    return (code == MOVE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_step_scheduler_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Loadable down-counter; done is high on the last cycle of an
//               interval of load_val cycles that starts on the cycle after load.
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/motor_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : motor_step_scheduler
// Description : Round-robin step/dir/enable sequencer for the theta and phi
//               tracker axes, with dead time on grant and reversal and a
//               per-grant step quota when both axes compete.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_step_scheduler
  import motor_pkg::*;
#(
  parameter int STEP_DIV  = 50000,
  parameter int PULSE_W   = 100,
  parameter int DEAD_T    = 1000,
  parameter int MAX_STEPS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] theta_pos,
  input  logic [1:0] theta_neg,
  input  logic [1:0] phi_pos,
  input  logic [1:0] phi_neg,
  output logic       theta_step,
  output logic       theta_dir,
  output logic       theta_en,
  output logic       phi_step,
  output logic       phi_dir,
  output logic       phi_en,
  output logic       busy,
  output logic       axis,
  output logic       fault
);

  localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(DEAD_T);
  localparam logic [CNT_W-1:0] HI_LEN    = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] LO_LEN    = CNT_W'(STEP_DIV - PULSE_W);
  localparam logic [CNT_W-1:0] QUOTA     = CNT_W'(MAX_STEPS);

  state_t           state_q, state_d;
  logic             axis_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d, steps_inc;
  logic             prio_q, prio_d;
  logic             grant;
  logic             drive_d;

  logic [1:0]       req_valid;
  logic [1:0]       req_dir;
  logic [1:0]       req_conflict;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;

  // Decode each axis; a simultaneous pos+neg is a conflict, not a request.
  always_comb begin
    req_valid[THETA]    = is_move(theta_pos) ^ is_move(theta_neg);
    req_dir[THETA]      = is_move(theta_pos);
    req_conflict[THETA] = is_move(theta_pos) & is_move(theta_neg);
    req_valid[PHI]      = is_move(phi_pos) ^ is_move(phi_neg);
    req_dir[PHI]        = is_move(phi_pos);
    req_conflict[PHI]   = is_move(phi_pos) & is_move(phi_neg);
  end

  step_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .done    (timer_done)
  );

  // Next-state, grant and step-count logic.
  always_comb begin
    state_d   = state_q;
    axis_d    = axis;
    dir_d     = dir_q;
    steps_d   = steps_q;
    prio_d    = prio_q;
    grant     = (&req_valid) ? prio_q : req_valid[PHI];
    steps_inc = (steps_q >= QUOTA) ? QUOTA : steps_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (enable && (|req_valid)) begin
          axis_d  = grant;
          dir_d   = req_dir[grant];
          steps_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!enable) begin
          state_d = RELEASE;
        end else if (timer_done) begin
          state_d = STEP_HI;
        end
      end
      STEP_HI: begin
        if (timer_done) begin
          state_d = STEP_LO;
        end
      end
      STEP_LO: begin
        if (timer_done) begin
          steps_d = steps_inc;
          if (!enable || !req_valid[axis]) begin
            state_d = RELEASE;
          end else if (req_dir[axis] != dir_q) begin
            dir_d   = req_dir[axis];
            state_d = SETUP;
          end else if ((steps_inc == QUOTA) && req_valid[~axis]) begin
            state_d = RELEASE;
          end else begin
            state_d = STEP_HI;
          end
        end
      end
      RELEASE: begin
        prio_d  = ~axis;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reload the interval timer on every state change.
  always_comb begin
    timer_load = (state_d != state_q);
    case (state_d)
      SETUP:   timer_val = SETUP_LEN;
      STEP_HI: timer_val = HI_LEN;
      STEP_LO: timer_val = LO_LEN;
      default: timer_val = '0;
    endcase
    drive_d = (state_d == SETUP) || (state_d == STEP_HI) || (state_d == STEP_LO);
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      axis    <= THETA;
      dir_q   <= 1'b0;
      steps_q <= '0;
      prio_q  <= THETA;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      axis    <= axis_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      prio_q  <= prio_d;
      fault   <= fault | (|req_conflict);
    end
  end

  // Registered pin drive derived from the next state; only the granted axis moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_step <= 1'b0;
      theta_dir  <= 1'b0;
      theta_en   <= 1'b0;
      phi_step   <= 1'b0;
      phi_dir    <= 1'b0;
      phi_en     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      theta_step <= (state_d == STEP_HI) && (axis_d == THETA);
      theta_dir  <= dir_d && (axis_d == THETA) && (state_d != IDLE);
      theta_en   <= drive_d && (axis_d == THETA);
      phi_step   <= (state_d == STEP_HI) && (axis_d == PHI);
      phi_dir    <= dir_d && (axis_d == PHI) && (state_d != IDLE);
      phi_en     <= drive_d && (axis_d == PHI);
      busy       <= (state_d != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_step_scheduler
// Description : Self-checking bench for motor_step_scheduler using a queue of
//               expected step-rise events plus inline level checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_step_scheduler;
  import motor_pkg::*;

  localparam int STEP_DIV  = 10;
  localparam int PULSE_W   = 3;
  localparam int DEAD_T    = 4;
  localparam int MAX_STEPS = 3;
  localparam int CNT_W     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] theta_pos = 2'b00, theta_neg = 2'b00, phi_pos = 2'b00, phi_neg = 2'b00;
  logic       theta_step, theta_dir, theta_en, phi_step, phi_dir, phi_en;
  logic       busy, axis, fault;

  motor_step_scheduler #(
    .STEP_DIV (STEP_DIV),
    .PULSE_W  (PULSE_W),
    .DEAD_T   (DEAD_T),
    .MAX_STEPS(MAX_STEPS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .theta_pos(theta_pos), .theta_neg(theta_neg),
    .phi_pos(phi_pos), .phi_neg(phi_neg),
    .theta_step(theta_step), .theta_dir(theta_dir), .theta_en(theta_en),
    .phi_step(phi_step), .phi_dir(phi_dir), .phi_en(phi_en),
    .busy(busy), .axis(axis), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   t;
    logic ax;
    logic dir;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e, o;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int overlap = 0;
  logic phi_seen = 1'b0;
  logic pt = 1'b0, pp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every step rise with the cycle it became visible and its direction.
  always @(negedge clk) begin
    if (theta_step && !pt) obs_q.push_back('{cyc, THETA, theta_dir});
    if (phi_step && !pp)   obs_q.push_back('{cyc, PHI, phi_dir});
    pt = theta_step;
    pp = phi_step;
    if (theta_en && phi_en) overlap++;
    if (phi_en) phi_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    theta_pos = STOP; theta_neg = STOP; phi_pos = STOP; phi_neg = STOP;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    tick(2);
    rst = 1'b0;
    tick(1);
    exp_q.delete();
    obs_q.delete();
    overlap = 0;
    phi_seen = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({theta_step, theta_dir, theta_en, phi_step, phi_dir, phi_en, busy, axis, fault} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000000",
               {theta_step, theta_dir, theta_en, phi_step, phi_dir, phi_en, busy, axis, fault});
    end
    do_reset();
    tick(5);
    checks++;
    if ({busy, theta_en, phi_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=000", {busy, theta_en, phi_en});
    end
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    c0 = cyc;
    theta_pos = MOVE;
    exp_q.push_back('{c0 + 5,  THETA, 1'b1});
    exp_q.push_back('{c0 + 15, THETA, 1'b1});
    exp_q.push_back('{c0 + 25, THETA, 1'b1});
    tick(1);
    checks++;
    if ({theta_en, theta_dir, busy, phi_en, theta_step} !== 5'b11100) begin
      failures++;
      $display("FAIL single_grant got=%b exp=11100", {theta_en, theta_dir, busy, phi_en, theta_step});
    end
    tick(6);
    checks++;
    if (theta_step !== 1'b1) begin
      failures++;
      $display("FAIL single_pulse_hi got=%b exp=1", theta_step);
    end
    tick(1);
    checks++;
    if (theta_step !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse_lo got=%b exp=0", theta_step);
    end
    tick(18);
    theta_pos = STOP;
    tick(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.t !== e.t || o.ax !== e.ax || o.dir !== e.dir) begin
        failures++;
        $display("FAIL single_rise got=%0d/%b/%b exp=%0d/%b/%b", o.t, o.ax, o.dir, e.t, e.ax, e.dir);
      end
    end
    checks++;
    if (phi_seen !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_phi_idle got=%b%b exp=00", phi_seen, busy);
    end
  endtask

  task automatic test_drop_mid_pulse();
    int c0;
    do_reset();
    c0 = cyc;
    theta_pos = MOVE;
    exp_q.push_back('{c0 + 5, THETA, 1'b1});
    tick(5);
    theta_pos = STOP;
    tick(2);
    checks++;
    if (theta_step !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse_kept got=%b exp=1", theta_step);
    end
    tick(1);
    checks++;
    if (theta_step !== 1'b0) begin
      failures++;
      $display("FAIL drop_pulse_end got=%b exp=0", theta_step);
    end
    tick(6);
    checks++;
    if ({theta_en, theta_step, busy} !== 3'b101) begin
      failures++;
      $display("FAIL drop_last_low got=%b exp=101", {theta_en, theta_step, busy});
    end
    tick(1);
    checks++;
    if ({theta_en, theta_step, busy} !== 3'b001) begin
      failures++;
      $display("FAIL drop_release got=%b exp=001", {theta_en, theta_step, busy});
    end
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got=%b exp=0", busy);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL drop_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.t !== e.t || o.ax !== e.ax || o.dir !== e.dir) begin
        failures++;
        $display("FAIL drop_rise got=%0d/%b/%b exp=%0d/%b/%b", o.t, o.ax, o.dir, e.t, e.ax, e.dir);
      end
    end
  endtask

  task automatic test_reversal();
    int c0;
    int en_drops;
    en_drops = 0;
    do_reset();
    c0 = cyc;
    theta_pos = MOVE;
    exp_q.push_back('{c0 + 5,  THETA, 1'b1});
    exp_q.push_back('{c0 + 19, THETA, 1'b0});
    tick(5);
    theta_pos = STOP;
    theta_neg = MOVE;
    for (int k = 6; k <= 19; k++) begin
      tick(1);
      if (!theta_en) en_drops++;
      if (k == 14) begin
        checks++;
        if (theta_dir !== 1'b1) begin
          failures++;
          $display("FAIL rev_dir_before got=%b exp=1", theta_dir);
        end
      end
      if (k == 15) begin
        checks++;
        if ({theta_dir, theta_step} !== 2'b00) begin
          failures++;
          $display("FAIL rev_dir_after got=%b exp=00", {theta_dir, theta_step});
        end
      end
    end
    checks++;
    if (en_drops != 0) begin
      failures++;
      $display("FAIL rev_en_held got=%0d exp=0", en_drops);
    end
    theta_neg = STOP;
    tick(15);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rev_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.t !== e.t || o.ax !== e.ax || o.dir !== e.dir) begin
        failures++;
        $display("FAIL rev_rise got=%0d/%b/%b exp=%0d/%b/%b", o.t, o.ax, o.dir, e.t, e.ax, e.dir);
      end
    end
  endtask

  task automatic test_arbitration();
    int c0;
    do_reset();
    c0 = cyc;
    theta_pos = MOVE;
    phi_pos = MOVE;
    for (int k = 0; k < 3; k++) exp_q.push_back('{c0 + 5 + 10 * k, THETA, 1'b1});
    for (int k = 0; k < 3; k++) exp_q.push_back('{c0 + 41 + 10 * k, PHI, 1'b1});
    exp_q.push_back('{c0 + 77, THETA, 1'b1});
    tick(35);
    checks++;
    if ({theta_en, phi_en, busy} !== 3'b001) begin
      failures++;
      $display("FAIL arb_release got=%b exp=001", {theta_en, phi_en, busy});
    end
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL arb_idle got=%b exp=0", busy);
    end
    tick(1);
    checks++;
    if ({phi_en, axis, theta_en} !== 3'b110) begin
      failures++;
      $display("FAIL arb_phi_grant got=%b exp=110", {phi_en, axis, theta_en});
    end
    tick(41);
    idle_inputs();
    tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL arb_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.t !== e.t || o.ax !== e.ax || o.dir !== e.dir) begin
        failures++;
        $display("FAIL arb_rise got=%0d/%b/%b exp=%0d/%b/%b", o.t, o.ax, o.dir, e.t, e.ax, e.dir);
      end
    end
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL arb_en_overlap got=%0d exp=0", overlap);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    phi_pos = MOVE;
    phi_neg = MOVE;
    tick(20);
    checks++;
    if ({phi_seen, busy, fault} !== 3'b001) begin
      failures++;
      $display("FAIL conflict_active got=%b exp=001", {phi_seen, busy, fault});
    end
    idle_inputs();
    tick(5);
    checks++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL conflict_sticky got=%b exp=1", fault);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL conflict_cleared got=%b exp=0", fault);
    end
  endtask

  task automatic test_reset_mid_op();
    int c0, c1, c2;
    do_reset();
    c0 = cyc;
    theta_pos = MOVE;
    exp_q.push_back('{c0 + 5, THETA, 1'b1});
    tick(5);
    theta_pos = STOP;
    tick(12);
    c1 = cyc;
    theta_pos = MOVE;
    exp_q.push_back('{c1 + 5, THETA, 1'b1});
    tick(6);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({theta_step, theta_dir, theta_en, phi_step, phi_dir, phi_en, busy, axis, fault} !== 9'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=000000000",
               {theta_step, theta_dir, theta_en, phi_step, phi_dir, phi_en, busy, axis, fault});
    end
    @(negedge clk);
    rst = 1'b0;
    theta_pos = 2'b10; theta_neg = 2'b11; phi_pos = STOP; phi_neg = 2'b10;
    tick(10);
    checks++;
    if ({busy, theta_en, phi_en} !== 3'b000) begin
      failures++;
      $display("FAIL rst_idle_codes got=%b exp=000", {busy, theta_en, phi_en});
    end
    c2 = cyc;
    theta_pos = MOVE; theta_neg = STOP; phi_pos = MOVE; phi_neg = STOP;
    exp_q.push_back('{c2 + 5, THETA, 1'b1});
    tick(5);
    checks++;
    if ({theta_step, phi_en, axis} !== 3'b100) begin
      failures++;
      $display("FAIL rst_prio_theta got=%b exp=100", {theta_step, phi_en, axis});
    end
    idle_inputs();
    tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rst_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.t !== e.t || o.ax !== e.ax || o.dir !== e.dir) begin
        failures++;
        $display("FAIL rst_rise got=%0d/%b/%b exp=%0d/%b/%b", o.t, o.ax, o.dir, e.t, e.ax, e.dir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop_mid_pulse();
    test_reversal();
    test_arbitration();
    test_conflict();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
